branch_resolve_unit: RTL and testbench
======================================

Name: branch_resolve_unit

Overview:
- Execute-stage neighbour of the branch-condition logic. It consumes the condition bit computed in EX, together with the branch/jump decode flags and the fetch-time prediction, and decides the outcome.
- Its own state is a small branch history table (BHT) of 2-bit saturating counters. Fetch reads the BHT combinationally to get a predicted direction.
- On a direction mispredict it issues a registered one-cycle PC redirect plus IF/ID and ID/EX flushes, and squashes the wrong-path instruction that occupies EX in that cycle.
- Free-running branch and mispredict counters provide performance statistics.

Parameters:
- XLEN, 32, data/PC width.
- BHT_ENTRIES, 16, number of 2-bit counters; must be a power of two, at least 2.
- IDX_W, $clog2(BHT_ENTRIES), BHT index width (derived; do not override).

Ports:
- clk  in  1  clock, rising edge.
- rst_n  in  1  asynchronous active-low reset.
- PredPC  in  XLEN  fetch-stage PC to predict.
- PredTaken  out  1  predicted direction for PredPC; combinational.
- ExValid  in  1  EX holds a real instruction.
- ExStall  in  1  EX is held this cycle.
- ExIsBranch  in  1  conditional branch in EX.
- ExIsJump  in  1  JAL/JALR in EX.
- ExCond  in  1  branch condition result from EX.
- ExPredTaken  in  1  prediction carried down with this instruction.
- ExPC  in  XLEN  PC of the EX instruction.
- ExTarget  in  XLEN  resolved taken target.
- Redirect  out  1  one-cycle PC redirect pulse, registered.
- RedirectPC  out  XLEN  corrected PC, registered.
- FlushIFID  out  1  flush IF/ID pipeline register, registered.
- FlushIDEX  out  1  flush ID/EX pipeline register, registered.
- BranchCount  out  32  resolved conditional branches.
- MispredCount  out  32  mispredicts, branches and jumps.

Behaviour:
- Reset (asynchronous, rst_n=0):
  - Redirect, FlushIFID, FlushIDEX = 0; RedirectPC = 0.
  - BranchCount and MispredCount = 0.
  - Every BHT entry = 2'b01 (weakly not-taken).
  - Reset asserted mid-operation aborts any pending redirect immediately.
- Index: idx(pc) = pc[IDX_W+1:2]. Aliasing is permitted.
- PredTaken = BHT[idx(PredPC)][1]. The read returns the pre-write value: there is no bypass of an update happening in the same cycle.
- Qualifiers (combinational):
  - Squash = Redirect register. The instruction in EX during a redirect cycle is wrong-path.
  - Act = ExValid & ~ExStall & ~Squash.
  - ActualTaken = ExIsJump | (ExIsBranch & ExCond).
  - Mispred = Act & (ExIsBranch | ExIsJump) & (ActualTaken != ExPredTaken).
  - CorrectPC = ActualTaken ? ExTarget : ExPC + 4, computed modulo 2^XLEN.
- Redirect register (latency 1 cycle from resolution):
  - If Mispred: next edge sets Redirect = FlushIFID = FlushIDEX = 1 and RedirectPC = CorrectPC.
  - Otherwise all three flags return to 0 and RedirectPC holds its value.
  - A redirect is always a single-cycle pulse. Back-to-back redirects cannot occur because of Squash.
- BHT update, on the edge when Act & ExIsBranch:
  - Taken: counter +1, saturating at 3.
  - Not taken: counter -1, saturating at 0.
  - Jumps never update the BHT.
  - Squashed or stalled instructions never update the BHT.
- Statistics, both wrapping from 0xFFFFFFFF to 0:
  - BranchCount += 1 when Act & ExIsBranch.
  - MispredCount += 1 when Mispred.
- ExIsBranch and ExIsJump both high is illegal; the result is treated as a jump. The bench asserts that this never happens.
- Stall: while ExStall=1 there is no update, no count and no redirect. Resolution occurs in the first cycle with ExStall=0.

Decomposition:
- Shared package bru_pkg:
  - typedef bht_ctr_t (logic [1:0]).
  - Constants BHT_RESET = 2'b01 and PC_STEP = 4.
- Sub-module sat_ctr2 (pure function or combinational module): next-state of a 2-bit saturating counter given taken/not-taken.
- The BHT array, redirect register and statistics counters stay in branch_resolve_unit.

Test Plan:
- Reset, then PredPC=0x100 -> PredTaken=0; Redirect, flushes and both counters = 0.
- ExValid=1, ExIsBranch=1, ExCond=1, ExPredTaken=0, ExPC=0x100, ExTarget=0x80 -> next cycle Redirect=1, RedirectPC=0x80, FlushIFID=FlushIDEX=1 for exactly one cycle. Afterwards PredTaken(0x100)=1 and PredTaken(0x140)=1 (alias). BranchCount=1, MispredCount=1.
- Not-taken branch at 0x104 with ExPredTaken=0, twice -> no redirect; entry 1 saturates at 0 and a third not-taken keeps it at 0; BranchCount=2, MispredCount=0.
- Mispredicting branch at 0x100 (taken, pred 0), then in the redirect cycle another mispredicting branch at 0x108 -> the second is squashed: no second pulse, BHT[2] unchanged, counts unchanged.
- Mispredicting branch at 0x100 held with ExStall=1 for 3 cycles -> no output activity. ExStall falls -> Redirect asserts on the following cycle with RedirectPC=0x80.
- ExIsJump=1, ExPredTaken=0, ExPC=0x10, ExTarget=0x200 -> Redirect to 0x200; BHT unchanged; MispredCount +1, BranchCount unchanged.

Source files
------------

// File: rtl/bru_pkg.sv
// rtl/bru_pkg.sv - shared types and constants for the branch resolve unit
package bru_pkg;

    typedef logic [1:0] bht_ctr_t;

    localparam bht_ctr_t BHT_RESET = 2'b01;
    localparam int       PC_STEP   = 4;

endpackage

// File: rtl/sat_ctr2.sv
// rtl/sat_ctr2.sv - next state of a 2-bit saturating direction counter
module sat_ctr2
    import bru_pkg::*;
(
    input  bht_ctr_t ctr_i,
    input  logic     taken_i,
    output bht_ctr_t ctr_o
);

    always_comb begin
        ctr_o = ctr_i;
        if (taken_i) begin
            if (ctr_i != 2'b11) ctr_o = ctr_i + 2'b01;
        end else begin
            if (ctr_i != 2'b00) ctr_o = ctr_i - 2'b01;
        end
    end

endmodule

// File: rtl/branch_resolve_unit.sv
// rtl/branch_resolve_unit.sv - EX-stage branch outcome, BHT training, redirect and statistics
module branch_resolve_unit
    import bru_pkg::*;
#(
    parameter  int XLEN        = 32,
    parameter  int BHT_ENTRIES = 16,
    localparam int IDX_W       = $clog2(BHT_ENTRIES)
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic [XLEN-1:0] PredPC,
    output logic            PredTaken,
    input  logic            ExValid,
    input  logic            ExStall,
    input  logic            ExIsBranch,
    input  logic            ExIsJump,
    input  logic            ExCond,
    input  logic            ExPredTaken,
    input  logic [XLEN-1:0] ExPC,
    input  logic [XLEN-1:0] ExTarget,
    output logic            Redirect,
    output logic [XLEN-1:0] RedirectPC,
    output logic            FlushIFID,
    output logic            FlushIDEX,
    output logic [31:0]     BranchCount,
    output logic [31:0]     MispredCount
);

    bht_ctr_t bht_q [BHT_ENTRIES];

    logic [IDX_W-1:0] pred_idx;
    logic [IDX_W-1:0] ex_idx;
    bht_ctr_t         ex_ctr_next;

    logic            squash, act, is_jump, is_branch, actual_taken, mispred;
    logic [XLEN-1:0] correct_pc;

    logic            redirect_q, redirect_d;
    logic [XLEN-1:0] redirect_pc_q, redirect_pc_d;
    logic [31:0]     branch_cnt_q, mispred_cnt_q;

    logic unused_pred_bits;
    assign unused_pred_bits = ^{PredPC[XLEN-1:IDX_W+2], PredPC[1:0]};

    assign pred_idx  = PredPC[IDX_W+1:2];
    assign ex_idx    = ExPC[IDX_W+1:2];
    // Read sees the pre-update counter; no same-cycle bypass.
    assign PredTaken = bht_q[pred_idx][1];

    // An illegal branch+jump decode resolves as a plain jump.
    assign is_jump      = ExIsJump;
    assign is_branch    = ExIsBranch & ~ExIsJump;
    assign squash       = redirect_q;
    assign act          = ExValid & ~ExStall & ~squash;
    assign actual_taken = is_jump | (is_branch & ExCond);
    assign mispred      = act & (is_branch | is_jump) & (actual_taken != ExPredTaken);
    assign correct_pc   = actual_taken ? ExTarget : ExPC + XLEN'(PC_STEP);

    assign redirect_d    = mispred;
    assign redirect_pc_d = mispred ? correct_pc : redirect_pc_q;

    sat_ctr2 u_sat_ctr2 (
        .ctr_i   (bht_q[ex_idx]),
        .taken_i (ExCond),
        .ctr_o   (ex_ctr_next)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < BHT_ENTRIES; i++) bht_q[i] <= BHT_RESET;
        end else if (act & is_branch) begin
            bht_q[ex_idx] <= ex_ctr_next;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            redirect_q    <= 1'b0;
            redirect_pc_q <= '0;
            branch_cnt_q  <= '0;
            mispred_cnt_q <= '0;
        end else begin
            redirect_q    <= redirect_d;
            redirect_pc_q <= redirect_pc_d;
            if (act & is_branch) branch_cnt_q <= branch_cnt_q + 32'd1;
            if (mispred)         mispred_cnt_q <= mispred_cnt_q + 32'd1;
        end
    end

    assign Redirect     = redirect_q;
    assign FlushIFID    = redirect_q;
    assign FlushIDEX    = redirect_q;
    assign RedirectPC   = redirect_pc_q;
    assign BranchCount  = branch_cnt_q;
    assign MispredCount = mispred_cnt_q;

endmodule

// File: tb/tb_branch_resolve_unit.sv
// tb/tb_branch_resolve_unit.sv - directed self-checking bench for branch_resolve_unit
module tb_branch_resolve_unit;

    logic        clk = 1'b0;
    logic        rst_n;
    logic [31:0] PredPC;
    logic        PredTaken;
    logic        ExValid, ExStall, ExIsBranch, ExIsJump, ExCond, ExPredTaken;
    logic [31:0] ExPC, ExTarget;
    logic        Redirect;
    logic [31:0] RedirectPC;
    logic        FlushIFID, FlushIDEX;
    logic [31:0] BranchCount, MispredCount;

    int n_cmp = 0;
    int n_err = 0;

    always #5 clk = ~clk;

    branch_resolve_unit dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .PredPC       (PredPC),
        .PredTaken    (PredTaken),
        .ExValid      (ExValid),
        .ExStall      (ExStall),
        .ExIsBranch   (ExIsBranch),
        .ExIsJump     (ExIsJump),
        .ExCond       (ExCond),
        .ExPredTaken  (ExPredTaken),
        .ExPC         (ExPC),
        .ExTarget     (ExTarget),
        .Redirect     (Redirect),
        .RedirectPC   (RedirectPC),
        .FlushIFID    (FlushIFID),
        .FlushIDEX    (FlushIDEX),
        .BranchCount  (BranchCount),
        .MispredCount (MispredCount)
    );

    always @(negedge clk) begin
        if (rst_n === 1'b1 && ExIsBranch === 1'b1 && ExIsJump === 1'b1) begin
            n_err++;
            $error("FAIL illegal_decode: observed branch=1 jump=1 expected not both");
        end
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed 0x%08h expected 0x%08h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic pred(input logic [31:0] pc, input logic exp, input string tag);
        PredPC = pc;
        #1;
        chk(tag, {31'd0, PredTaken}, {31'd0, exp});
    endtask

    task automatic ex_set(input logic v, input logic st, input logic br, input logic jp,
                          input logic cond, input logic pt, input logic [31:0] pc,
                          input logic [31:0] tgt);
        ExValid = v; ExStall = st; ExIsBranch = br; ExIsJump = jp;
        ExCond = cond; ExPredTaken = pt; ExPC = pc; ExTarget = tgt;
    endtask

    task automatic chk_out(input string tag, input logic rd, input logic [31:0] rpc,
                           input logic [31:0] bc, input logic [31:0] mc);
        chk({tag, ".redirect"}, {31'd0, Redirect}, {31'd0, rd});
        chk({tag, ".flush_ifid"}, {31'd0, FlushIFID}, {31'd0, rd});
        chk({tag, ".flush_idex"}, {31'd0, FlushIDEX}, {31'd0, rd});
        chk({tag, ".redirect_pc"}, RedirectPC, rpc);
        chk({tag, ".branch_cnt"}, BranchCount, bc);
        chk({tag, ".mispred_cnt"}, MispredCount, mc);
    endtask

    initial begin
        rst_n = 1'b0;
        PredPC = 32'h100;
        ex_set(0, 0, 0, 0, 0, 0, 32'h0, 32'h0);
        repeat (2) tick();
        chk_out("reset", 0, 32'h0, 0, 0);
        pred(32'h100, 0, "reset.pred_100");
        rst_n = 1'b1;

        // taken branch predicted not-taken
        tick();
        ex_set(1, 0, 1, 0, 1, 0, 32'h100, 32'h80);
        tick();
        chk_out("mp1", 1, 32'h80, 1, 1);
        ex_set(0, 0, 0, 0, 0, 0, 32'h0, 32'h0);
        pred(32'h100, 1, "mp1.pred_100");
        pred(32'h140, 1, "mp1.pred_alias_140");
        tick();
        chk_out("mp1.pulse_end", 0, 32'h80, 1, 1);

        // three not-taken branches at 0x104 drive entry 1 to 0 and hold it there
        ex_set(1, 0, 1, 0, 0, 0, 32'h104, 32'h40);
        repeat (3) tick();
        chk_out("nt3", 0, 32'h80, 4, 1);
        ex_set(0, 0, 0, 0, 0, 0, 32'h0, 32'h0);
        pred(32'h104, 0, "nt3.pred_104");

        // entry 0 saturates at 3, then one not-taken leaves it weakly taken
        ex_set(1, 0, 1, 0, 1, 1, 32'h100, 32'h80);
        repeat (2) tick();
        chk_out("sat3", 0, 32'h80, 6, 1);
        ex_set(1, 0, 1, 0, 0, 1, 32'h100, 32'h80);
        tick();
        chk_out("sat3.nt_mp", 1, 32'h104, 7, 2);
        ex_set(0, 0, 0, 0, 0, 0, 32'h0, 32'h0);
        pred(32'h100, 1, "sat3.pred_100");
        tick();

        // fall-through PC wraps modulo 2^32
        ex_set(1, 0, 1, 0, 0, 1, 32'hFFFF_FFFC, 32'h1234);
        tick();
        chk_out("wrap", 1, 32'h0, 8, 3);
        ex_set(0, 0, 0, 0, 0, 0, 32'h0, 32'h0);
        tick();

        // wrong-path branch in the redirect cycle is squashed
        ex_set(1, 0, 1, 0, 1, 0, 32'h100, 32'h90);
        tick();
        chk_out("sq.first", 1, 32'h90, 9, 4);
        ex_set(1, 0, 1, 0, 1, 0, 32'h108, 32'h300);
        tick();
        chk_out("sq.second", 0, 32'h90, 9, 4);
        ex_set(0, 0, 0, 0, 0, 0, 32'h0, 32'h0);
        pred(32'h108, 0, "sq.pred_108");

        // stalled mispredict resolves only once the stall drops
        ex_set(1, 1, 1, 0, 1, 0, 32'h100, 32'h80);
        repeat (3) tick();
        chk_out("stall.held", 0, 32'h90, 9, 4);
        ExStall = 1'b0;
        tick();
        chk_out("stall.release", 1, 32'h80, 10, 5);
        ex_set(0, 0, 0, 0, 0, 0, 32'h0, 32'h0);
        tick();

        // mispredicted jump: redirect, no BHT or branch-count change
        ex_set(1, 0, 0, 1, 0, 0, 32'h10, 32'h200);
        tick();
        chk_out("jmp.mp", 1, 32'h200, 10, 6);
        ex_set(0, 0, 0, 0, 0, 0, 32'h0, 32'h0);
        pred(32'h10, 0, "jmp.pred_10");
        tick();

        // correctly predicted jump
        ex_set(1, 0, 0, 1, 0, 1, 32'h20, 32'h400);
        tick();
        chk_out("jmp.ok", 0, 32'h200, 10, 6);
        ex_set(0, 0, 0, 0, 0, 0, 32'h0, 32'h0);
        tick();

        // asynchronous reset kills a live redirect pulse
        ex_set(1, 0, 1, 0, 1, 0, 32'h104, 32'h500);
        tick();
        chk_out("arst.pre", 1, 32'h500, 11, 7);
        ex_set(0, 0, 0, 0, 0, 0, 32'h0, 32'h0);
        #1 rst_n = 1'b0;
        #1;
        chk_out("arst.mid", 0, 32'h0, 0, 0);
        pred(32'h100, 0, "arst.pred_100");
        tick();
        rst_n = 1'b1;
        tick();
        chk_out("arst.post", 0, 32'h0, 0, 0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
